// File: rtl/native_vtg_if.sv
// Native video timing bundle: strobe, blanking, syncs and position.
// master drives the bundle, slave consumes it (axis2native vtg_i).
interface native_vtg_if #(
   parameter int CW = 12
);
   logic          vtg_ce;
   logic          active;
   logic          hblank;
   logic          vblank;
   logic          hsync;
   logic          vsync;
   logic          sof;
   logic [CW-1:0] hcnt;
   logic [CW-1:0] vcnt;
   logic          running;

   modport master (
      output vtg_ce,
      output active,
      output hblank,
      output vblank,
      output hsync,
      output vsync,
      output sof,
      output hcnt,
      output vcnt,
      output running
   );

   modport slave (
      input vtg_ce,
      input active,
      input hblank,
      input vblank,
      input hsync,
      input vsync,
      input sof,
      input hcnt,
      input vcnt,
      input running
   );
endinterface

// File: rtl/native_vtg.sv
// Parameterised native video timing generator, natv_clk domain.
// Starts and stops only on frame boundaries; all outputs registered.
module native_vtg #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int CW       = 12
) (
   input  logic         natv_clk,
   input  logic         rst_n,
   input  logic         en,
   native_vtg_if.master vtg
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] HA      = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VA      = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   state_e        state_q;
   logic [CW-1:0] h_q;
   logic [CW-1:0] v_q;
   logic [CW-1:0] h_d;
   logic [CW-1:0] v_d;
   logic          last_w;
   logic          hs_w;
   logic          vs_w;

   logic          ce_q;
   logic          act_q;
   logic          hb_q;
   logic          vb_q;
   logic          hs_q;
   logic          vs_q;
   logic          sof_q;
   logic          run_q;
   logic [CW-1:0] hcnt_q;
   logic [CW-1:0] vcnt_q;

   function automatic logic is_act(input logic [CW-1:0] h,
                                   input logic [CW-1:0] v);
      return (h < HA) && (v < VA);
   endfunction

   // (h_q, v_q) is the position the next clock edge will present
   always_comb begin
      h_d    = h_q + 1'b1;
      v_d    = v_q;
      last_w = (h_q == H_LAST) && (v_q == V_LAST);
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      hs_w = (h_q >= HS_BEG) && (h_q <= HS_LAST);
      vs_w = (v_q >= VS_BEG) && (v_q <= VS_LAST);
   end

   always_ff @(posedge natv_clk) begin
      if (!rst_n || state_q == IDLE) begin
         act_q  <= 1'b0;
         hb_q   <= 1'b1;
         vb_q   <= 1'b1;
         hs_q   <= ~HS_POL;
         vs_q   <= ~VS_POL;
         sof_q  <= 1'b0;
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         act_q  <= is_act(h_q, v_q);
         hb_q   <= h_q >= HA;
         vb_q   <= v_q >= VA;
         hs_q   <= hs_w ? HS_POL : ~HS_POL;
         vs_q   <= vs_w ? VS_POL : ~VS_POL;
         sof_q  <= (h_q == '0) && (v_q == '0);
         hcnt_q <= h_q;
         vcnt_q <= v_q;
      end

      if (!rst_n) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         ce_q    <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               h_q   <= '0;
               v_q   <= '0;
               ce_q  <= en;
               run_q <= en;
               if (en) begin
                  state_q <= RUN;
               end
            end
            RUN, DRAIN: begin
               run_q <= 1'b1;
               if (en) begin
                  state_q <= RUN;
                  h_q     <= h_d;
                  v_q     <= v_d;
                  ce_q    <= is_act(h_d, v_d);
               end else if (last_w) begin
                  // final pixel of the frame goes out; nothing follows
                  state_q <= IDLE;
                  h_q     <= '0;
                  v_q     <= '0;
                  ce_q    <= 1'b0;
               end else begin
                  state_q <= DRAIN;
                  h_q     <= h_d;
                  v_q     <= v_d;
                  ce_q    <= is_act(h_d, v_d);
               end
            end
            default: begin
               state_q <= IDLE;
               h_q     <= '0;
               v_q     <= '0;
               ce_q    <= 1'b0;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign vtg.vtg_ce  = ce_q;
   assign vtg.active  = act_q;
   assign vtg.hblank  = hb_q;
   assign vtg.vblank  = vb_q;
   assign vtg.hsync   = hs_q;
   assign vtg.vsync   = vs_q;
   assign vtg.sof     = sof_q;
   assign vtg.hcnt    = hcnt_q;
   assign vtg.vcnt    = vcnt_q;
   assign vtg.running = run_q;

endmodule

// File: tb/tb_native_vtg.sv
// Directed bench for native_vtg: 16x8 raster, active-high and
// active-low sync instances driven by the same stimulus.
module tb_native_vtg;

   localparam int CW = 12;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   int   errors = 0;
   int   checks = 0;
   int   ce_cnt = 0;
   int   sof_cnt = 0;
   logic prev_ce = 1'b0;

   always #5 clk = ~clk;

   native_vtg_if #(.CW(CW)) p_if ();
   native_vtg_if #(.CW(CW)) n_if ();

   native_vtg #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
   ) u_pos (
      .natv_clk(clk),
      .rst_n   (rst_n),
      .en      (en),
      .vtg     (p_if)
   );

   native_vtg #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
   ) u_neg (
      .natv_clk(clk),
      .rst_n   (rst_n),
      .en      (en),
      .vtg     (n_if)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_act(input int k);
      int h = k % 16;
      int v = (k / 16) % 8;
      return (h < 8) && (v < 4);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ce"},    32'(p_if.vtg_ce),  0);
      chk({tag, ".act"},   32'(p_if.active),  0);
      chk({tag, ".hb"},    32'(p_if.hblank),  1);
      chk({tag, ".vb"},    32'(p_if.vblank),  1);
      chk({tag, ".hs"},    32'(p_if.hsync),   0);
      chk({tag, ".vs"},    32'(p_if.vsync),   0);
      chk({tag, ".sof"},   32'(p_if.sof),     0);
      chk({tag, ".hcnt"},  32'(p_if.hcnt),    0);
      chk({tag, ".vcnt"},  32'(p_if.vcnt),    0);
      chk({tag, ".run"},   32'(p_if.running), 0);
      chk({tag, ".n_hs"},  32'(n_if.hsync),   1);
      chk({tag, ".n_vs"},  32'(n_if.vsync),   1);
      chk({tag, ".n_ce"},  32'(n_if.vtg_ce),  0);
   endtask

   task automatic chk_pos(input int k, input logic ce_exp);
      int h = k % 16;
      int v = (k / 16) % 8;
      chk("hcnt",    32'(p_if.hcnt),    32'(h));
      chk("vcnt",    32'(p_if.vcnt),    32'(v));
      chk("active",  32'(p_if.active),  32'(exp_act(k)));
      chk("ce_lead", 32'(p_if.active),  32'(prev_ce));
      chk("hblank",  32'(p_if.hblank),  32'(h >= 8));
      chk("vblank",  32'(p_if.vblank),  32'(v >= 4));
      chk("hsync",   32'(p_if.hsync),   32'(h == 10 || h == 11));
      chk("vsync",   32'(p_if.vsync),   32'(v == 5));
      chk("sof",     32'(p_if.sof),     32'(h == 0 && v == 0));
      chk("running", 32'(p_if.running), 1);
      chk("vtg_ce",  32'(p_if.vtg_ce),  32'(ce_exp));
      chk("n_hsync", 32'(n_if.hsync),   32'(!(h == 10 || h == 11)));
      chk("n_vsync", 32'(n_if.vsync),   32'(v != 5));
      chk("n_act",   32'(n_if.active),  32'(exp_act(k)));
      chk("n_ce",    32'(n_if.vtg_ce),  32'(ce_exp));
      chk("n_hcnt",  32'(n_if.hcnt),    32'(h));
      prev_ce = p_if.vtg_ce;
      if (p_if.vtg_ce) ce_cnt++;
      if (p_if.sof) sof_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      tick();
      tick();
      chk_idle("reset");

      rst_n = 1'b1;
      tick();
      tick();
      chk_idle("idle");

      // start: one priming cycle with vtg_ce high, then (0,0)
      en = 1'b1;
      tick();
      chk("prime.ce",  32'(p_if.vtg_ce),  1);
      chk("prime.act", 32'(p_if.active),  0);
      chk("prime.run", 32'(p_if.running), 1);
      prev_ce = p_if.vtg_ce;
      ce_cnt  = 0;
      sof_cnt = 0;

      for (int k = 0; k < 384; k++) begin
         tick();
         chk_pos(k % 128, exp_act(k + 1));
         if (k % 128 == 127) begin
            chk("ce_per_frame",  32'(ce_cnt),  32);
            chk("sof_per_frame", 32'(sof_cnt), 1);
            ce_cnt  = 0;
            sof_cnt = 0;
         end
      end

      // drop en at frame cycle 40: frame completes, then idle
      for (int k = 0; k < 128; k++) begin
         tick();
         chk_pos(k, (k == 127) ? 1'b0 : exp_act(k + 1));
         if (k == 39) en = 1'b0;
      end
      chk("drain.sof", 32'(sof_cnt), 1);
      chk("drain.ce",  32'(ce_cnt),  31);
      tick();
      chk_idle("drained");
      tick();
      tick();
      chk_idle("idle2");

      // restart; en low 40..59 must not disturb the raster
      en = 1'b1;
      tick();
      chk("restart.ce", 32'(p_if.vtg_ce), 1);
      prev_ce = p_if.vtg_ce;
      sof_cnt = 0;
      for (int k = 0; k < 199; k++) begin
         tick();
         chk_pos(k % 128, exp_act(k + 1));
         if (k == 39) en = 1'b0;
         if (k == 59) en = 1'b1;
      end
      chk("gapless.sof", 32'(sof_cnt), 2);

      // reset while showing (6,4)
      rst_n = 1'b0;
      tick();
      chk_idle("mid_reset");
      rst_n = 1'b1;
      tick();
      chk("rearm.ce",  32'(p_if.vtg_ce), 1);
      chk("rearm.hb",  32'(p_if.hblank), 1);
      chk("rearm.act", 32'(p_if.active), 0);
      prev_ce = p_if.vtg_ce;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk_pos(k, exp_act(k + 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/native_vtg.md
Name: native_vtg

Overview:
- Parameterised native video timing generator in the `natv_clk` domain.
- Produces the `vtg_ce` / `active` / `hblank` / `vblank` / `hsync` / `vsync` bundle consumed by `axis2native` through its `vtg_i` port.
- `vtg_ce` leads `active` by exactly one cycle, so the downstream stage can pop one pixel per `vtg_ce` and present it aligned with `active`.
- Supports start/stop on frame boundaries so the HDMI path never sees a truncated frame.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (cycles)
- H_SYNC, 44, horizontal sync width
- H_BP, 148, horizontal back porch
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vertical sync width
- V_BP, 36, vertical back porch
- HS_POL, 1, hsync asserted level (1 = active-high)
- VS_POL, 1, vsync asserted level
- CW, 12, counter width; H_TOTAL and V_TOTAL must each be ≤ 2^CW

Ports:
- natv_clk  in  1  pixel clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  run request; level-sensitive
- vtg_ce  out  1  pixel fetch strobe; high when the next cycle is an active pixel
- active  out  1  active video
- hblank  out  1  horizontal blanking
- vblank  out  1  vertical blanking
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- sof  out  1  one-cycle pulse coincident with the first active pixel of a frame
- hcnt  out  CW  horizontal position of the current output cycle
- vcnt  out  CW  vertical position of the current output cycle
- running  out  1  high while the state is RUN or DRAIN

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
- Line order: active, front porch, sync, back porch. The frame follows the same order in lines.
- Position counters (h, v):
  - Advance one step per cycle in RUN and DRAIN.
  - h wraps H_TOTAL-1 → 0 and increments v.
  - v wraps V_TOTAL-1 → 0.
- Decode at position (h, v):
  - hblank = h ≥ H_ACTIVE.
  - vblank = v ≥ V_ACTIVE.
  - active = !hblank && !vblank.
  - hsync asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, changing only at h = 0.
- Output registration:
  - All outputs are registered; `hcnt`, `vcnt`, `active`, blank, sync and `sof` all describe the same position in the same cycle.
  - `vtg_ce` is the registered decode of the following position. Invariant: `active` at cycle t+1 equals `vtg_ce` at cycle t, including across line and frame wraps.
- State machine (IDLE, RUN, DRAIN):
  - IDLE with en=1 → RUN. The first output cycle after the transition is position (0,0), so `vtg_ce` is high in the transition cycle itself.
  - RUN with en=0 → DRAIN.
  - DRAIN with en=1 → RUN, with no gap and no counter disturbance.
  - DRAIN at position (H_TOTAL-1, V_TOTAL-1) → IDLE.
  - en toggling mid-frame never shortens or restarts a frame.
- In IDLE:
  - h = v = 0; hcnt = vcnt = 0.
  - vtg_ce = 0, active = 0, hblank = vblank = 1.
  - Syncs deasserted; sof = 0; running = 0.
- Reset:
  - rst_n = 0 sampled at a `natv_clk` edge forces IDLE and the IDLE output values above on that edge.
  - This applies mid-frame or mid-line with no completion.
  - The first output position after reset release plus en is always (0,0).
- sof = 1 only at position (0,0) while running.

Test Plan:
Common setup for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=4 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2 (V_TOTAL=8); frame = 128 cycles.
- Reset then en=1 held → per line: active high for 8 cycles, hblank high for 8; hsync high at h=10,11; vblank high on lines 4–7; vsync high for all 16 cycles of line 5; sof every 128 cycles; 32 `vtg_ce` pulses per frame.
- Every cycle over 3 frames → `active` == previous-cycle `vtg_ce`, including across h=15→0 and v=7→0; hcnt/vcnt match the decoded flags.
- en dropped at frame cycle 40 → frame completes to (15,7), then IDLE (vtg_ce=0, hblank=vblank=1, running=0); exactly one more sof was seen.
- en dropped at cycle 40, re-raised at cycle 60 → no gap; output identical to en held high.
- rst_n=0 for 1 cycle at frame cycle 70 (h=6, v=4) → next cycle all outputs at IDLE values; en high afterwards → restart at (0,0) with sof.
- HS_POL=0, VS_POL=0 → hsync/vsync inverted in reset, in IDLE and during sync; all other outputs unchanged.
